cv_tile_scheduler: RTL and testbench

- Layer-level sequencer for one convolution layer. Splits the output volume into tiles and drives the data loader through a load-weight / load-input / compute / store-output command sequence for each tile.
- Supplies the per-PE tile origin and extent signals (Iori/Oori/Hori/Wori, Iext/Oext/Hext/Wext) that the loader and the CVEngine consume.
- Sits between the instruction decoder (start/done) and the data loader plus the PE array.

---
 rtl/cv_pkg.sv | 43 ++++
 rtl/cv_tile_scheduler_if.sv | 26 ++
 rtl/cv_tile_counter.sv | 47 ++++
 rtl/cv_tile_scheduler.sv | 107 ++++++++++
 tb/tb_cv_tile_scheduler.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cv_pkg.sv
// Shared types, widths and tile arithmetic helpers for the convolution tile scheduler.
package cv_pkg;
   localparam int DW  = 13;
   localparam int LW_ = 11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LW,
      S_LIF,
      S_COMP,
      S_SOF,
      S_NEXT,
      S_DONE
   } state_t;

   // Layer geometry in DW-bit signed form; nbase is -pad, the input-space origin offset.
   typedef struct packed {
      logic signed [DW-1:0] o_lim;
      logic signed [DW-1:0] h_lim;
      logic signed [DW-1:0] w_lim;
      logic signed [DW-1:0] t_o;
      logic signed [DW-1:0] t_h;
      logic signed [DW-1:0] t_w;
      logic signed [DW-1:0] k;
      logic signed [DW-1:0] nbase;
   } layer_t;

   function automatic logic signed [DW-1:0] tsize(input logic [LW_-1:0] v);
      return (v == '0) ? DW'(1) : DW'(v);
   endfunction

   function automatic logic signed [DW-1:0] tile_ext(input logic signed [DW-1:0] size,
                                                     input logic signed [DW-1:0] remaining,
                                                     input logic signed [DW-1:0] k);
      logic signed [DW-1:0] m;
      m = (size < remaining) ? size : remaining;
      return m + k - DW'(1);
   endfunction

   function automatic logic nonpos(input logic signed [DW-1:0] v);
      return v[DW-1] | (v == '0);
   endfunction
endpackage

// File: rtl/cv_tile_scheduler_if.sv
// Decoder/loader/PE-facing signal bundle of the tile scheduler.
interface cv_tile_scheduler_if;
   import cv_pkg::*;

   logic                 start;
   logic [LW_-1:0]       I, O, H, W, TO, TH, TW;
   logic [4:0]           K;
   logic [1:0]           pad;
   logic                 busy, layer_done;
   logic                 load_weight, load_input, store_output, dl_done;
   logic                 pe_compute, pe_compute_done;
   logic signed [DW-1:0] Iori, Oori, Hori, Wori;
   logic signed [DW-1:0] Iext, Oext, Hext, Wext;

   modport master (
      output start, I, O, H, W, TO, TH, TW, K, pad, dl_done, pe_compute_done,
      input  busy, layer_done, load_weight, load_input, store_output, pe_compute,
      input  Iori, Oori, Hori, Wori, Iext, Oext, Hext, Wext
   );

   modport slave (
      input  start, I, O, H, W, TO, TH, TW, K, pad, dl_done, pe_compute_done,
      output busy, layer_done, load_weight, load_input, store_output, pe_compute,
      output Iori, Oori, Hori, Wori, Iext, Oext, Hext, Wext
   );
endinterface

// File: rtl/cv_tile_counter.sv
// Stepped tile counter: walks 0..limit-1 in steps and registers the tile
// origin (count + base), the clipped extent and the last-tile flag.
module cv_tile_counter
   import cv_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_init,
   input  logic                 i_adv,
   input  logic signed [DW-1:0] i_base,
   input  logic signed [DW-1:0] i_step,
   input  logic signed [DW-1:0] i_limit,
   input  logic signed [DW-1:0] i_k,
   output logic signed [DW-1:0] o_value,
   output logic signed [DW-1:0] o_ext,
   output logic                 o_last
);
   logic signed [DW-1:0] r_cnt, r_value, r_ext, w_next;
   logic                 r_last;

   // Advancing from the last tile wraps to 0 so the enclosing loop level can carry.
   always_comb begin
      w_next = r_cnt;
      if (i_init)
         w_next = '0;
      else if (i_adv)
         w_next = r_last ? '0 : r_cnt + i_step;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_value <= '0;
         r_ext   <= '0;
         r_last  <= 1'b0;
      end else if (i_init || i_adv) begin
         r_cnt   <= w_next;
         r_value <= w_next + i_base;
         r_ext   <= tile_ext(i_step, i_limit - w_next, i_k);
         r_last  <= (w_next + i_step >= i_limit);
      end
   end

   assign o_value = r_value;
   assign o_ext   = r_ext;
   assign o_last  = r_last;
endmodule

// File: rtl/cv_tile_scheduler.sv
// Layer sequencer: walks output tiles (ot, ht, wt) and drives the loader/PE
// through load-weight, load-input, compute and store-output for each tile.
module cv_tile_scheduler
   import cv_pkg::*;
(
   input logic                clk,
   input logic                rst_n,
   cv_tile_scheduler_if.slave bus
);
   state_t               r_state, w_state_nxt;
   layer_t               w_raw, r_lay, w_lay;
   logic signed [DW-1:0] r_iext;
   logic                 w_init, w_adv_o, w_adv_h, w_adv_w;
   logic                 w_last_o, w_last_h, w_last_w;
   logic signed [DW-1:0] w_oori, w_oext, w_hori, w_hext, w_wori, w_wext;

   always_comb begin
      w_raw.o_lim = DW'(bus.O);
      w_raw.h_lim = DW'(bus.H) + DW'({bus.pad, 1'b0}) - DW'(bus.K) + DW'(1);
      w_raw.w_lim = DW'(bus.W) + DW'({bus.pad, 1'b0}) - DW'(bus.K) + DW'(1);
      w_raw.t_o   = tsize(bus.TO);
      w_raw.t_h   = tsize(bus.TH);
      w_raw.t_w   = tsize(bus.TW);
      w_raw.k     = DW'(bus.K);
      w_raw.nbase = DW'(0) - DW'(bus.pad);
   end

   // Counters are seeded in the accept cycle, before r_lay holds the new layer.
   assign w_lay = (r_state == S_IDLE) ? w_raw : r_lay;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_lay   <= '0;
         r_iext  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_init) begin
            r_lay  <= w_raw;
            r_iext <= DW'(bus.I);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_init      = 1'b0;
      w_adv_o     = 1'b0;
      w_adv_h     = 1'b0;
      w_adv_w     = 1'b0;
      case (r_state)
         S_IDLE: if (bus.start) begin
            w_init      = 1'b1;
            w_state_nxt = (nonpos(w_raw.h_lim) || nonpos(w_raw.w_lim)) ? S_DONE : S_LW;
         end
         S_LW:   if (bus.dl_done)         w_state_nxt = S_LIF;
         S_LIF:  if (bus.dl_done)         w_state_nxt = S_COMP;
         S_COMP: if (bus.pe_compute_done) w_state_nxt = S_SOF;
         S_SOF:  if (bus.dl_done)         w_state_nxt = S_NEXT;
         S_NEXT: begin
            if (w_last_w && w_last_h && w_last_o) begin
               w_state_nxt = S_DONE;
            end else begin
               w_adv_w     = 1'b1;
               w_adv_h     = w_last_w;
               w_adv_o     = w_last_w && w_last_h;
               w_state_nxt = (w_last_w && w_last_h) ? S_LW : S_LIF;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   cv_tile_counter u_cnt_o (
      .clk(clk), .rst_n(rst_n), .i_init(w_init), .i_adv(w_adv_o),
      .i_base('0), .i_step(w_lay.t_o), .i_limit(w_lay.o_lim), .i_k(DW'(1)),
      .o_value(w_oori), .o_ext(w_oext), .o_last(w_last_o)
   );

   cv_tile_counter u_cnt_h (
      .clk(clk), .rst_n(rst_n), .i_init(w_init), .i_adv(w_adv_h),
      .i_base(w_lay.nbase), .i_step(w_lay.t_h), .i_limit(w_lay.h_lim), .i_k(w_lay.k),
      .o_value(w_hori), .o_ext(w_hext), .o_last(w_last_h)
   );

   cv_tile_counter u_cnt_w (
      .clk(clk), .rst_n(rst_n), .i_init(w_init), .i_adv(w_adv_w),
      .i_base(w_lay.nbase), .i_step(w_lay.t_w), .i_limit(w_lay.w_lim), .i_k(w_lay.k),
      .o_value(w_wori), .o_ext(w_wext), .o_last(w_last_w)
   );

   assign bus.busy         = (r_state != S_IDLE);
   assign bus.layer_done   = (r_state == S_DONE);
   assign bus.load_weight  = (r_state == S_LW);
   assign bus.load_input   = (r_state == S_LIF);
   assign bus.pe_compute   = (r_state == S_COMP);
   assign bus.store_output = (r_state == S_SOF);
   assign bus.Iori         = '0;
   assign bus.Iext         = r_iext;
   assign bus.Oori         = w_oori;
   assign bus.Oext         = w_oext;
   assign bus.Hori         = w_hori;
   assign bus.Hext         = w_hext;
   assign bus.Wori         = w_wori;
   assign bus.Wext         = w_wext;
endmodule

// File: tb/tb_cv_tile_scheduler.sv
// Bench for cv_tile_scheduler: loader/PE responders, transaction log and a
// loop-nest reference model of the per-tile command sequence.
module tb_cv_tile_scheduler;
   import cv_pkg::*;

   typedef struct {int I, O, H, W, K, pad, TO, TH, TW;} cfg_t;
   typedef struct {int kind, oori, oext, iori, iext, hori, hext, wori, wext;} txn_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   last_dl_cyc, done_cyc;
   txn_t got[$];
   txn_t expq[$];

   cv_tile_scheduler_if bus();
   cv_tile_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
         $error("check %s observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic txn_t snap(input int kind);
      txn_t t;
      t.kind = kind;
      t.oori = int'(bus.Oori); t.oext = int'(bus.Oext);
      t.iori = int'(bus.Iori); t.iext = int'(bus.Iext);
      t.hori = int'(bus.Hori); t.hext = int'(bus.Hext);
      t.wori = int'(bus.Wori); t.wext = int'(bus.Wext);
      return t;
   endfunction

   function automatic bit txn_eq(input txn_t a, input txn_t b);
      return a.kind == b.kind && a.oori == b.oori && a.oext == b.oext &&
             a.iori == b.iori && a.iext == b.iext && a.hori == b.hori &&
             a.hext == b.hext && a.wori == b.wori && a.wext == b.wext;
   endfunction

   function automatic int cmd_level(input int kind);
      case (kind)
         0:       return int'(bus.load_weight);
         1:       return int'(bus.load_input);
         2:       return int'(bus.pe_compute);
         default: return int'(bus.store_output);
      endcase
   endfunction

   function automatic cfg_t rand_cfg();
      cfg_t c;
      c.I = $urandom_range(1, 8);  c.O = $urandom_range(1, 6);
      c.H = $urandom_range(1, 6);  c.W = $urandom_range(1, 6);
      c.K = $urandom_range(1, 5);  c.pad = $urandom_range(0, 2);
      c.TO = $urandom_range(0, 3); c.TH = $urandom_range(0, 3); c.TW = $urandom_range(0, 3);
      return c;
   endfunction

   task automatic apply_cfg(input cfg_t c);
      bus.I = LW_'(c.I);   bus.O = LW_'(c.O);   bus.H = LW_'(c.H);   bus.W = LW_'(c.W);
      bus.TO = LW_'(c.TO); bus.TH = LW_'(c.TH); bus.TW = LW_'(c.TW);
      bus.K = 5'(c.K);     bus.pad = 2'(c.pad);
   endtask

   // Expected command stream: weights once per output-channel tile, then
   // load-input/compute/store for every (row, column) tile inside it.
   task automatic build_exp(input cfg_t c);
      int   hout, wout, t_o, t_h, t_w;
      txn_t t;
      expq.delete();
      hout = c.H + 2 * c.pad - c.K + 1;
      wout = c.W + 2 * c.pad - c.K + 1;
      if (hout <= 0 || wout <= 0) return;
      t_o = (c.TO == 0) ? 1 : c.TO;
      t_h = (c.TH == 0) ? 1 : c.TH;
      t_w = (c.TW == 0) ? 1 : c.TW;
      for (int ot = 0; ot < c.O; ot += t_o)
         for (int ht = 0; ht < hout; ht += t_h)
            for (int wt = 0; wt < wout; wt += t_w) begin
               t.oori = ot;         t.oext = imin(t_o, c.O - ot);
               t.iori = 0;          t.iext = c.I;
               t.hori = ht - c.pad; t.hext = imin(t_h, hout - ht) + c.K - 1;
               t.wori = wt - c.pad; t.wext = imin(t_w, wout - wt) + c.K - 1;
               if (ht == 0 && wt == 0) begin
                  t.kind = 0;
                  expq.push_back(t);
               end
               for (int k = 1; k <= 3; k++) begin
                  t.kind = k;
                  expq.push_back(t);
               end
            end
   endtask

   task automatic cmp_logs(input string tag);
      chk({tag, "_count"}, got.size(), expq.size());
      for (int i = 0; i < got.size() && i < expq.size(); i++) begin
         chk({tag, "_kind"}, got[i].kind, expq[i].kind);
         chk({tag, "_oori"}, got[i].oori, expq[i].oori);
         chk({tag, "_oext"}, got[i].oext, expq[i].oext);
         chk({tag, "_iori"}, got[i].iori, expq[i].iori);
         chk({tag, "_iext"}, got[i].iext, expq[i].iext);
         chk({tag, "_hori"}, got[i].hori, expq[i].hori);
         chk({tag, "_hext"}, got[i].hext, expq[i].hext);
         chk({tag, "_wori"}, got[i].wori, expq[i].wori);
         chk({tag, "_wext"}, got[i].wext, expq[i].wext);
      end
   endtask

   // Called at a negedge; returns at a negedge. The loader and PE accept a
   // command in the cycle they see it, answer 1..3 cycles later, and are idle
   // (sampling commands again) in the cycle right after their done pulse.
   task automatic run_layer(input cfg_t c, input bit disturb, input bit abort_comp);
      bit   ld_busy = 0, pe_busy = 0, fin = 0, stray = 0;
      int   ld_cnt = 0, pe_cnt = 0, ld_prev = -1, pe_prev = -1, n;
      txn_t ld_snap, pe_snap;
      got.delete();
      last_dl_cyc = -1;
      done_cyc = -1;
      apply_cfg(c);
      bus.start = 1'b1;
      for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
         @(negedge clk);
         bus.start = 1'b0;
         bus.dl_done = 1'b0;
         bus.pe_compute_done = 1'b0;
         if (bus.layer_done) begin
            fin = 1;
            done_cyc = cyc;
            chk("busy_at_layer_done", int'(bus.busy), 1);
         end else begin
            chk("busy_during_layer", int'(bus.busy), 1);
            if (disturb) begin
               apply_cfg(rand_cfg());
               bus.start = ($urandom_range(0, 3) == 0);
            end
            if (ld_prev >= 0) chk("cmd_low_after_dl_done", cmd_level(ld_prev), 0);
            if (pe_prev >= 0) chk("compute_low_after_done", int'(bus.pe_compute), 0);
            ld_prev = -1;
            pe_prev = -1;
            if (ld_busy) begin
               chk("load_cmd_stable", int'(txn_eq(snap(ld_snap.kind), ld_snap) &&
                                           cmd_level(ld_snap.kind) == 1), 1);
               ld_cnt--;
               if (ld_cnt == 0) begin
                  bus.dl_done = 1'b1;
                  ld_busy = 0;
                  ld_prev = ld_snap.kind;
                  last_dl_cyc = cyc;
               end
            end else begin
               n = int'(bus.load_weight) + int'(bus.load_input) + int'(bus.store_output);
               if (n != 0) begin
                  chk("single_load_cmd", n, 1);
                  ld_snap = snap(bus.load_weight ? 0 : (bus.load_input ? 1 : 3));
                  got.push_back(ld_snap);
                  ld_busy = 1;
                  ld_cnt = $urandom_range(1, 3);
               end
            end
            if (pe_busy) begin
               chk("compute_stable", int'(txn_eq(snap(2), pe_snap) && bus.pe_compute), 1);
               pe_cnt--;
               if (pe_cnt == 0) begin
                  bus.pe_compute_done = 1'b1;
                  pe_busy = 0;
                  pe_prev = 2;
               end
            end else if (bus.pe_compute) begin
               pe_snap = snap(2);
               got.push_back(pe_snap);
               pe_busy = 1;
               pe_cnt = $urandom_range(1, 3);
            end
            if (disturb && !stray && !ld_busy && bus.pe_compute && !bus.dl_done) begin
               bus.dl_done = 1'b1;
               stray = 1;
            end
            if (abort_comp && bus.pe_compute) begin
               bus.dl_done = 1'b0;
               bus.pe_compute_done = 1'b0;
               #1 rst_n = 1'b0;
               #1;
               chk("abort_pe_compute", int'(bus.pe_compute), 0);
               chk("abort_busy", int'(bus.busy), 0);
               chk("abort_load_input", int'(bus.load_input), 0);
               chk("abort_layer_done", int'(bus.layer_done), 0);
               chk("abort_hori", int'(bus.Hori), 0);
               chk("abort_oext", int'(bus.Oext), 0);
               chk("abort_iext", int'(bus.Iext), 0);
               @(negedge clk);
               chk("abort_held_idle", int'(bus.busy), 0);
               rst_n = 1'b1;
               return;
            end
         end
      end
      if (!fin) chk("layer_done_timeout", 0, 1);
      @(negedge clk);
      chk("layer_done_one_cycle", int'(bus.layer_done), 0);
      chk("idle_after_done", int'(bus.busy), 0);
   endtask

   initial begin
      cfg_t c1, c2, cdeg, cr;
      int   nk[4];
      c1   = '{I: 2, O: 4, H: 4, W: 4, K: 3, pad: 1, TO: 2, TH: 2, TW: 4};
      c2   = '{I: 1, O: 3, H: 5, W: 5, K: 3, pad: 0, TO: 2, TH: 2, TW: 3};
      cdeg = '{I: 1, O: 1, H: 3, W: 3, K: 5, pad: 0, TO: 1, TH: 1, TW: 1};
      bus.start = 1'b0;
      bus.dl_done = 1'b0;
      bus.pe_compute_done = 1'b0;
      apply_cfg(c1);

      repeat (2) @(negedge clk);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_layer_done", int'(bus.layer_done), 0);
      chk("rst_cmds", int'(bus.load_weight) + int'(bus.load_input) +
                      int'(bus.pe_compute) + int'(bus.store_output), 0);
      chk("rst_hori", int'(bus.Hori), 0);
      chk("rst_wext", int'(bus.Wext), 0);
      rst_n = 1'b1;
      @(negedge clk);

      build_exp(c1);
      run_layer(c1, 0, 0);
      cmp_logs("t1");
      nk = '{0, 0, 0, 0};
      foreach (got[i]) nk[got[i].kind]++;
      chk("t1_n_lw", nk[0], 2);
      chk("t1_n_lif", nk[1], 4);
      chk("t1_n_comp", nk[2], 4);
      chk("t1_n_sof", nk[3], 4);
      chk("t1_len", got.size(), 14);
      if (got.size() == 14) begin
         chk("t1_lif1_kind", got[1].kind, 1);
         chk("t1_lif1_hori", got[1].hori, -1);
         chk("t1_lif1_wori", got[1].wori, -1);
         chk("t1_lif1_hext", got[1].hext, 4);
         chk("t1_lif1_wext", got[1].wext, 6);
         chk("t1_lif1_oext", got[1].oext, 2);
         chk("t1_lif2_hori", got[4].hori, 1);
         chk("t1_last_is_sof", got[13].kind, 3);
      end
      chk("t1_done_after_last_store", done_cyc - last_dl_cyc, 2);

      build_exp(c2);
      run_layer(c2, 0, 0);
      cmp_logs("t2");
      chk("t2_len", got.size(), 14);
      if (got.size() == 14) begin
         chk("t2_lif1_hext", got[1].hext, 4);
         chk("t2_lif1_hori", got[1].hori, 0);
         chk("t2_lif2_hext", got[4].hext, 3);
         chk("t2_lif2_hori", got[4].hori, 2);
         chk("t2_lw2_kind", got[7].kind, 0);
         chk("t2_lw2_oori", got[7].oori, 2);
         chk("t2_lw2_oext", got[7].oext, 1);
      end

      build_exp(c1);
      run_layer(c1, 1, 0);
      cmp_logs("t3_disturbed");

      run_layer(c1, 0, 1);
      @(negedge clk);
      build_exp(c1);
      run_layer(c1, 0, 0);
      cmp_logs("t4_after_reset");

      build_exp(cdeg);
      run_layer(cdeg, 0, 0);
      chk("deg_done_latency", done_cyc, 0);
      chk("deg_no_cmds", got.size(), 0);
      chk("deg_model_empty", expq.size(), 0);

      for (int r = 0; r < 6; r++) begin
         cr = rand_cfg();
         build_exp(cr);
         run_layer(cr, (r % 2) == 1, 0);
         cmp_logs("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
